// File: rtl/coin_acceptor.sv
// Coin-sensor front end for vending_machine: synchronise, debounce, jam detection, coin FIFO and paced money output.
// Optional running credit total is enabled by defining COIN_ACCEPTOR_CREDIT_EN.
`timescale 1ns/1ps

module coin_acceptor_sensor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic rise,
  output logic stuck
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int JW  = $clog2(JAM_CYCLES + 1);

  logic           sync1_q, sync2_q;
  logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
  logic           level_q, level_d;
  logic           rise_q, rise_d;
  logic [JW-1:0]  hi_cnt_q, hi_cnt_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    hi_cnt_d  = hi_cnt_q;

    if (sync2_q != level_q) begin
      if (deb_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        level_d   = ~level_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DBW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end

    rise_d = level_d & ~level_q;

    // High-time counter saturates at the jam threshold so stuck stays asserted.
    if (level_q) begin
      if (hi_cnt_q != JW'(JAM_CYCLES)) hi_cnt_d = hi_cnt_q + JW'(1);
    end else begin
      hi_cnt_d = '0;
    end

    stuck = (hi_cnt_d == JW'(JAM_CYCLES));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      hi_cnt_q  <= '0;
    end else begin
      sync1_q   <= raw_in;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      hi_cnt_q  <= hi_cnt_d;
    end
  end

  assign rise = rise_q;

endmodule

module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin10_in,
  input  logic       coin50_in,
  input  logic       accept_en,
  output logic [1:0] money,
  output logic       coin_return,
  output logic       jam,
  output logic       busy
`ifdef COIN_ACCEPTOR_CREDIT_EN
  ,
  output logic [7:0] credit_total
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] MONEY_NONE = 2'b00;
  localparam logic [1:0] MONEY_10   = 2'b01;
  localparam logic [1:0] MONEY_50   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_GAP
  } state_e;

  logic rise10, rise50, stuck10, stuck50;

  coin_acceptor_sensor #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_sensor10 (
    .clk    (clk),
    .reset  (reset),
    .raw_in (coin10_in),
    .rise   (rise10),
    .stuck  (stuck10)
  );

  coin_acceptor_sensor #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_sensor50 (
    .clk    (clk),
    .reset  (reset),
    .raw_in (coin50_in),
    .rise   (rise50),
    .stuck  (stuck50)
  );

  logic [1:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          coin_return_q, coin_return_d;
  logic          jam_q, jam_d;
  logic          busy_q, busy_d;

  logic          ev10, ev50, single, full, push, pop;
  logic [1:0]    push_code;

  // Event qualification and queue bookkeeping.
  always_comb begin
    ev10          = rise10 & ~jam_q;
    ev50          = rise50 & ~jam_q;
    single        = ev10 ^ ev50;
    pop           = (state_q == S_EMIT);
    full          = (count_q == CW'(FIFO_DEPTH));
    push          = single & (~full | pop);
    push_code     = ev50 ? MONEY_50 : MONEY_10;
    coin_return_d = (ev10 & ev50) | (single & full & ~pop);
    jam_d         = jam_q | stuck10 | stuck50;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Output pacing: one EMIT cycle, then GAP_CYCLES forced idle cycles.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && accept_en) state_d = S_EMIT;
      end
      S_EMIT: begin
        state_d   = S_GAP;
        gap_cnt_d = '0;
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      gap_cnt_q     <= '0;
      coin_return_q <= 1'b0;
      jam_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      coin_return_q <= coin_return_d;
      jam_q         <= jam_d;
      busy_q        <= busy_d;
    end
  end

  // NOTE: queue storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_code;
  end

  always_comb begin
    money = MONEY_NONE;
    if (state_q == S_EMIT) money = fifo_mem_q[rd_ptr_q];
  end

  assign coin_return = coin_return_q;
  assign jam         = jam_q;
  assign busy        = busy_q;

`ifdef COIN_ACCEPTOR_CREDIT_EN
  logic [7:0] credit_q, credit_d;
  logic [8:0] credit_sum;

  always_comb begin
    credit_d   = credit_q;
    credit_sum = {1'b0, credit_q} + ((money == MONEY_50) ? 9'd5 : 9'd1);
    if (pop) credit_d = (credit_sum > 9'd255) ? 8'hFF : credit_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) credit_q <= '0;
    else       credit_q <= credit_d;
  end

  assign credit_total = credit_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: per-cycle vector table plus directed sequences for queueing and jam.
`timescale 1ns/1ps

module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin10_in, coin50_in, accept_en;
  logic [1:0] money;
  logic       coin_return, jam, busy;

  int checks = 0;
  int errors = 0;

  coin_acceptor dut (
    .clk         (clk),
    .reset       (reset),
    .coin10_in   (coin10_in),
    .coin50_in   (coin50_in),
    .accept_en   (accept_en),
    .money       (money),
    .coin_return (coin_return),
    .jam         (jam),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       c10;
    logic       c50;
    logic       acc;
    logic [1:0] money;
    logic       ret;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // Hold a coin on one sensor long enough to debounce, then release long enough to debounce low.
  task automatic insert_coin(input logic is50, output int rets, output int moneys);
    rets   = 0;
    moneys = 0;
    coin10_in = ~is50;
    coin50_in = is50;
    repeat (8) begin
      tick();
      rets += int'(coin_return);
      if (money != 2'b00) moneys++;
    end
    coin10_in = 1'b0;
    coin50_in = 1'b0;
    repeat (8) begin
      tick();
      rets += int'(coin_return);
      if (money != 2'b00) moneys++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rets, moneys, idx_prev, seen, waited;
    logic [1:0] codes [4];
    logic [1:0] exp_codes [4];

    // Vector table: inputs applied before an edge, outputs compared 1 ns after it.
    for (int t = 0; t < 20; t++) vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0});
    // Clean coin10, high 10 cycles: money=01 exactly after edge k+7, busy k+6..k+9.
    for (int t = 0; t < 16; t++)
      vecs.push_back('{(t < 10), 1'b0, 1'b1, (t == 7) ? 2'b01 : 2'b00, 1'b0, (t >= 6 && t <= 9)});
    for (int t = 0; t < 4; t++) vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0});
    // Chattering sensor never debounces.
    for (int t = 0; t < 20; t++) vecs.push_back('{(t % 2 == 0), 1'b0, 1'b1, 2'b00, 1'b0, 1'b0});
    for (int t = 0; t < 10; t++) vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0});
    // Both sensors rise together: one coin_return after edge k+6, nothing queued.
    for (int t = 0; t < 16; t++)
      vecs.push_back('{(t < 10), (t < 10), 1'b1, 2'b00, (t == 6), 1'b0});
    for (int t = 0; t < 6; t++) vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0});

    coin10_in = 1'b0;
    coin50_in = 1'b0;
    accept_en = 1'b1;
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      coin10_in = vecs[i].c10;
      coin50_in = vecs[i].c50;
      accept_en = vecs[i].acc;
      tick();
      check($sformatf("vec%0d money", i), 32'(money), 32'(vecs[i].money));
      check($sformatf("vec%0d coin_return", i), 32'(coin_return), 32'(vecs[i].ret));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d jam", i), 32'(jam), 32'd0);
    end

    // Fill the queue with accept_en low, overflow with a fifth coin, then drain in order.
    accept_en = 1'b0;
    exp_codes[0] = 2'b10;
    exp_codes[1] = 2'b01;
    exp_codes[2] = 2'b01;
    exp_codes[3] = 2'b10;
    for (int c = 0; c < 4; c++) begin
      insert_coin(exp_codes[c] == 2'b10, rets, moneys);
      check($sformatf("fill%0d coin_return count", c), 32'(rets), 32'd0);
      check($sformatf("fill%0d money count", c), 32'(moneys), 32'd0);
    end
    check("fill busy", 32'(busy), 32'd1);
    insert_coin(1'b0, rets, moneys);
    check("overflow coin_return count", 32'(rets), 32'd1);
    check("overflow money count", 32'(moneys), 32'd0);

    accept_en = 1'b1;
    seen     = 0;
    idx_prev = -100;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (money != 2'b00) begin
        if (seen < 4) codes[seen] = money;
        if (seen > 0) check($sformatf("drain gap%0d >= 3", seen), 32'(t - idx_prev - 1 >= 3), 32'd1);
        idx_prev = t;
        seen++;
      end
    end
    check("drain coin count", 32'(seen), 32'd4);
    for (int c = 0; c < 4; c++)
      if (c < seen) check($sformatf("drain code%0d", c), 32'(codes[c]), 32'(exp_codes[c]));
    check("drain busy idle", 32'(busy), 32'd0);

    // Reset during an emission drops money on the next cycle.
    accept_en = 1'b0;
    insert_coin(1'b1, rets, moneys);
    accept_en = 1'b1;
    waited = 0;
    while (money == 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
    check("midreset emission reached", 32'(money), 32'h2);
    reset = 1'b1;
    tick();
    check("midreset money", 32'(money), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("midreset stays quiet", 32'(money), 32'd0);

    // Jam: coin50 held 100 cycles; debounced at edge k+5, high-count 64 at edge k+69.
    accept_en = 1'b1;
    for (int t = 0; t < 100; t++) begin
      coin50_in = 1'b1;
      tick();
      if (t == 7)  check("jam first coin money", 32'(money), 32'h2);
      if (t == 68) check("jam before threshold", 32'(jam), 32'd0);
      if (t == 69) check("jam at threshold", 32'(jam), 32'd1);
    end
    coin50_in = 1'b0;
    repeat (20) tick();
    check("jam held after release", 32'(jam), 32'd1);
    insert_coin(1'b0, rets, moneys);
    repeat (10) begin
      tick();
      if (money != 2'b00) moneys++;
    end
    check("jam coin10 money count", 32'(moneys), 32'd0);
    check("jam coin10 coin_return count", 32'(rets), 32'd0);
    do_reset();
    check("jam cleared by reset", 32'(jam), 32'd0);
    check("post reset busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
